// File: rtl/guess_engine_n.sv
// Guessing-game core: random secret generation, digit-by-digit guess entry,
// sequential exact/partial scoring and chance tracking.
module guess_engine_n #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_W      = 4,
    parameter int unsigned DIGIT_MAX    = 9,
    parameter int unsigned MAX_CHANCES  = 7,
    parameter int unsigned ALLOW_REPEAT = 0,
    localparam int unsigned IdxW = $clog2(NUM_DIGITS + 1),
    localparam int unsigned ChW  = $clog2(MAX_CHANCES + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          p0_pulse,
    input  logic                          p1_pulse,
    input  logic [DIGIT_W-1:0]            sw_val,
    input  logic                          sw_valid,
    input  logic [DIGIT_W-1:0]            lfsr_val,
    output logic [2:0]                    state,
    output logic [NUM_DIGITS*DIGIT_W-1:0] target,
    output logic [NUM_DIGITS*DIGIT_W-1:0] guess,
    output logic [IdxW-1:0]               guess_idx,
    output logic [DIGIT_W-1:0]            candidate,
    output logic [ChW-1:0]                chances_left,
    output logic [IdxW-1:0]               exact_cnt,
    output logic [IdxW-1:0]               partial_cnt,
    output logic                          score_valid,
    output logic                          dup_err
);

    localparam int unsigned CntW = $clog2(2 * NUM_DIGITS + 1);
    localparam int unsigned VecW = NUM_DIGITS * DIGIT_W;
    localparam logic [IdxW-1:0] NumD    = IdxW'(NUM_DIGITS);
    localparam logic [CntW-1:0] NumCnt  = CntW'(NUM_DIGITS);
    localparam logic [CntW-1:0] LastCnt = CntW'(2 * NUM_DIGITS - 1);
    localparam logic [ChW-1:0]  MaxCh   = ChW'(MAX_CHANCES);

    if (ALLOW_REPEAT == 0 && DIGIT_MAX + 1 < NUM_DIGITS) begin : g_param_err
        $error("guess_engine_n: too few distinct digits for a repeat-free secret");
    end

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StGen   = 3'd1,
        StInput = 3'd2,
        StScore = 3'd3,
        StCheck = 3'd4,
        StWin   = 3'd5,
        StLose  = 3'd6
    } state_e;

    state_e                 state_q, state_d;
    logic [VecW-1:0]        target_q, target_d, guess_q, guess_d;
    logic [IdxW-1:0]        idx_q, idx_d, gen_k_q, gen_k_d;
    logic [IdxW-1:0]        exact_q, exact_d, partial_q, partial_d;
    logic [IdxW-1:0]        ex_acc_q, ex_acc_d, pa_acc_q, pa_acc_d;
    logic [ChW-1:0]         chances_q, chances_d;
    logic [CntW-1:0]        sc_cnt_q, sc_cnt_d;
    logic [NUM_DIGITS-1:0]  used_t_q, used_t_d, used_g_q, used_g_d;
    logic [DIGIT_W-1:0]     cand_q;
    logic                   score_valid_q, score_valid_d, dup_err_q, dup_err_d;

    logic                   gen_dup, in_dup, phase_a, ug_cur, found;
    logic [CntW-1:0]        pi;
    logic [DIGIT_W-1:0]     g_cur, t_cur;

    // Helpers: duplicate lookups and the digit pair addressed by the score counter.
    always_comb begin
        gen_dup = 1'b0;
        in_dup  = 1'b0;
        phase_a = (sc_cnt_q < NumCnt);
        pi      = phase_a ? sc_cnt_q : sc_cnt_q - NumCnt;
        g_cur   = '0;
        t_cur   = '0;
        ug_cur  = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i < 32'(gen_k_q) && target_q[i*DIGIT_W +: DIGIT_W] == lfsr_val) gen_dup = 1'b1;
            if (i < 32'(idx_q) && guess_q[i*DIGIT_W +: DIGIT_W] == sw_val) in_dup = 1'b1;
            if (i == 32'(pi)) begin
                g_cur  = guess_q[i*DIGIT_W +: DIGIT_W];
                t_cur  = target_q[i*DIGIT_W +: DIGIT_W];
                ug_cur = used_g_q[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        guess_d       = guess_q;
        idx_d         = idx_q;
        gen_k_d       = gen_k_q;
        exact_d       = exact_q;
        partial_d     = partial_q;
        ex_acc_d      = ex_acc_q;
        pa_acc_d      = pa_acc_q;
        chances_d     = chances_q;
        sc_cnt_d      = sc_cnt_q;
        used_t_d      = used_t_q;
        used_g_d      = used_g_q;
        score_valid_d = 1'b0;
        dup_err_d     = 1'b0;
        found         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (p1_pulse) begin
                    state_d   = StGen;
                    target_d  = '0;
                    guess_d   = '0;
                    idx_d     = '0;
                    gen_k_d   = '0;
                    exact_d   = '0;
                    partial_d = '0;
                    chances_d = MaxCh;
                end
            end
            StGen: begin
                if (32'(lfsr_val) <= DIGIT_MAX && (ALLOW_REPEAT != 0 || !gen_dup)) begin
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        if (i == 32'(gen_k_q)) target_d[i*DIGIT_W +: DIGIT_W] = lfsr_val;
                    end
                    gen_k_d = gen_k_q + 1'b1;
                    if (gen_k_q == NumD - 1'b1) state_d = StInput;
                end
            end
            StInput: begin
                // Submit takes priority; a coincident entry pulse is dropped.
                if (p1_pulse) begin
                    if (idx_q == NumD) begin
                        state_d  = StScore;
                        sc_cnt_d = '0;
                        used_t_d = '0;
                        used_g_d = '0;
                        ex_acc_d = '0;
                        pa_acc_d = '0;
                    end
                end else if (p0_pulse && sw_valid && idx_q < NumD) begin
                    if (ALLOW_REPEAT == 0 && in_dup) begin
                        dup_err_d = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                            if (i == 32'(idx_q)) guess_d[i*DIGIT_W +: DIGIT_W] = sw_val;
                        end
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StScore: begin
                sc_cnt_d = sc_cnt_q + 1'b1;
                if (phase_a) begin
                    if (g_cur == t_cur) begin
                        ex_acc_d = ex_acc_q + 1'b1;
                        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                            if (i == 32'(pi)) begin
                                used_t_d[i] = 1'b1;
                                used_g_d[i] = 1'b1;
                            end
                        end
                    end
                end else if (!ug_cur) begin
                    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
                        if (!found && !used_t_q[j] && target_q[j*DIGIT_W +: DIGIT_W] == g_cur) begin
                            found       = 1'b1;
                            used_t_d[j] = 1'b1;
                        end
                    end
                    if (found) pa_acc_d = pa_acc_q + 1'b1;
                end
                if (sc_cnt_q == LastCnt) state_d = StCheck;
            end
            StCheck: begin
                exact_d       = ex_acc_q;
                partial_d     = pa_acc_q;
                score_valid_d = 1'b1;
                chances_d     = chances_q - 1'b1;
                if (ex_acc_q == NumD) begin
                    state_d = StWin;
                end else if (chances_q == ChW'(1)) begin
                    state_d = StLose;
                end else begin
                    guess_d = '0;
                    idx_d   = '0;
                    state_d = StInput;
                end
            end
            StWin, StLose: begin
                if (p1_pulse) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            target_q      <= '0;
            guess_q       <= '0;
            idx_q         <= '0;
            gen_k_q       <= '0;
            exact_q       <= '0;
            partial_q     <= '0;
            ex_acc_q      <= '0;
            pa_acc_q      <= '0;
            chances_q     <= MaxCh;
            sc_cnt_q      <= '0;
            used_t_q      <= '0;
            used_g_q      <= '0;
            cand_q        <= '0;
            score_valid_q <= 1'b0;
            dup_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            guess_q       <= guess_d;
            idx_q         <= idx_d;
            gen_k_q       <= gen_k_d;
            exact_q       <= exact_d;
            partial_q     <= partial_d;
            ex_acc_q      <= ex_acc_d;
            pa_acc_q      <= pa_acc_d;
            chances_q     <= chances_d;
            sc_cnt_q      <= sc_cnt_d;
            used_t_q      <= used_t_d;
            used_g_q      <= used_g_d;
            score_valid_q <= score_valid_d;
            dup_err_q     <= dup_err_d;
            if (sw_valid) cand_q <= sw_val;
        end
    end

    assign state        = state_q;
    assign target       = target_q;
    assign guess        = guess_q;
    assign guess_idx    = idx_q;
    assign candidate    = cand_q;
    assign chances_left = chances_q;
    assign exact_cnt    = exact_q;
    assign partial_cnt  = partial_q;
    assign score_valid  = score_valid_q;
    assign dup_err      = dup_err_q;

endmodule

// File: tb/tb_guess_engine_n.sv
// Bench for guess_engine_n: default instance plus a repeat-permitting instance
// sharing the same stimulus.
module tb_guess_engine_n;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_pulse = 1'b0, p1_pulse = 1'b0, sw_valid = 1'b0;
    logic [3:0]  sw_val = '0, lfsr_val = '0;

    logic [2:0]  state, b_state;
    logic [15:0] target, guess, b_target, b_guess;
    logic [2:0]  guess_idx, exact_cnt, partial_cnt, b_guess_idx, b_exact_cnt, b_partial_cnt;
    logic [3:0]  candidate, b_candidate;
    logic [2:0]  chances_left, b_chances_left;
    logic        score_valid, dup_err, b_score_valid, b_dup_err;

    localparam logic [2:0] SIdle = 3'd0, SGen = 3'd1, SInput = 3'd2, SScore = 3'd3;
    localparam logic [2:0] SWin = 3'd5, SLose = 3'd6;

    guess_engine_n dut (
        .clk(clk), .reset_n(reset_n), .p0_pulse(p0_pulse), .p1_pulse(p1_pulse),
        .sw_val(sw_val), .sw_valid(sw_valid), .lfsr_val(lfsr_val),
        .state(state), .target(target), .guess(guess), .guess_idx(guess_idx),
        .candidate(candidate), .chances_left(chances_left), .exact_cnt(exact_cnt),
        .partial_cnt(partial_cnt), .score_valid(score_valid), .dup_err(dup_err)
    );

    guess_engine_n #(.ALLOW_REPEAT(1)) dut_rep (
        .clk(clk), .reset_n(reset_n), .p0_pulse(p0_pulse), .p1_pulse(p1_pulse),
        .sw_val(sw_val), .sw_valid(sw_valid), .lfsr_val(lfsr_val),
        .state(b_state), .target(b_target), .guess(b_guess), .guess_idx(b_guess_idx),
        .candidate(b_candidate), .chances_left(b_chances_left), .exact_cnt(b_exact_cnt),
        .partial_cnt(b_partial_cnt), .score_valid(b_score_valid), .dup_err(b_dup_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] g;
        int          ex;
        int          pa;
        int          ch;
        logic [2:0]  st;
    } vec_t;

    typedef struct {
        int ex;
        int pa;
        int ch;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse1();
        p1_pulse = 1'b1;
        step();
        p1_pulse = 1'b0;
    endtask

    task automatic enter(input logic [3:0] d);
        sw_val   = d;
        sw_valid = 1'b1;
        p0_pulse = 1'b1;
        step();
        p0_pulse = 1'b0;
        sw_valid = 1'b0;
    endtask

    task automatic gen4(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            lfsr_val = v[i*4 +: 4];
            step();
        end
    endtask

    // Submit current guess and return cycles from the submit edge to score_valid.
    task automatic submit_wait(output int cyc);
        pulse1();
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!score_valid && cyc < 30);
    endtask

    task automatic apply(input vec_t v);
        int cyc;
        for (int i = 0; i < 4; i++) enter(v.g[i*4 +: 4]);
        sbq.push_back('{ex: v.ex, pa: v.pa, ch: v.ch});
        submit_wait(cyc);
        chk("score_latency", cyc, 9);
        chk("state_after_check", int'(state), int'(v.st));
    endtask

    // Scoreboard: score_valid pops the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (reset_n && score_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_score_valid", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("exact_cnt", int'(exact_cnt), mon_e.ex);
                chk("partial_cnt", int'(partial_cnt), mon_e.pa);
                chk("chances_left", int'(chances_left), mon_e.ch);
            end
        end
    end

    vec_t tbl[4];

    initial begin
        int cyc;
        vec_t v;

        // Target after GEN will be 3,5,9,1; chances continue from 6.
        tbl[0] = '{g: 16'h8642, ex: 0, pa: 0, ch: 5, st: SInput};
        tbl[1] = '{g: 16'h5319, ex: 0, pa: 4, ch: 4, st: SInput};
        tbl[2] = '{g: 16'h9153, ex: 2, pa: 2, ch: 3, st: SInput};
        tbl[3] = '{g: 16'h1953, ex: 4, pa: 0, ch: 2, st: SWin};

        repeat (3) step();
        chk("rst_state", int'(state), 0);
        chk("rst_chances", int'(chances_left), 7);
        chk("rst_target", int'(target), 0);
        chk("rst_candidate", int'(candidate), 0);
        reset_n = 1'b1;
        step();
        chk("idle_hold", int'(state), int'(SIdle));

        // GEN with rejections of a repeat and an out-of-range sample.
        pulse1();
        chk("gen_enter", int'(state), int'(SGen));
        lfsr_val = 4'd3;  step();
        lfsr_val = 4'd3;  step();
        lfsr_val = 4'd12; step();
        lfsr_val = 4'd5;  step();
        lfsr_val = 4'd9;  step();
        chk("gen_not_done", int'(state), int'(SGen));
        lfsr_val = 4'd1;  step();
        chk("gen_done", int'(state), int'(SInput));
        chk("gen_target", int'(target), 16'h1953);

        // Entry rules: duplicate, early submit, simultaneous pulses.
        enter(4'd1);
        enter(4'd5);
        chk("idx_two", int'(guess_idx), 2);
        enter(4'd5);
        chk("dup_err_pulse", int'(dup_err), 1);
        chk("dup_no_write", int'(guess_idx), 2);
        step();
        chk("dup_err_once", int'(dup_err), 0);
        enter(4'd3);
        pulse1();
        chk("early_submit_ignored", int'(state), int'(SInput));
        sw_val = 4'd9; sw_valid = 1'b1; p0_pulse = 1'b1; p1_pulse = 1'b1;
        step();
        p0_pulse = 1'b0; p1_pulse = 1'b0; sw_valid = 1'b0;
        chk("simul_idx", int'(guess_idx), 3);
        chk("simul_guess", int'(guess), 16'h0351);
        enter(4'd7);
        chk("guess_full", int'(guess), 16'h7351);
        chk("candidate", int'(candidate), 7);
        sbq.push_back('{ex: 1, pa: 2, ch: 6});
        submit_wait(cyc);
        chk("score_latency", cyc, 9);
        chk("next_state", int'(state), int'(SInput));
        chk("idx_cleared", int'(guess_idx), 0);
        chk("guess_cleared", int'(guess), 0);

        for (int r = 0; r < 4; r++) apply(tbl[r]);
        chk("win_target_hold", int'(target), 16'h1953);
        enter(4'd2);
        chk("win_p0_ignored", int'(state), int'(SWin));
        pulse1();
        chk("win_to_idle", int'(state), int'(SIdle));

        // Losing round: seven misses.
        pulse1();
        gen4(16'h3210);
        chk("lose_gen_target", int'(target), 16'h3210);
        for (int k = 1; k <= 7; k++) begin
            v = '{g: 16'h7654, ex: 0, pa: 0, ch: 7 - k, st: (k == 7) ? SLose : SInput};
            apply(v);
        end
        chk("lose_chances", int'(chances_left), 0);
        pulse1();
        chk("lose_to_idle", int'(state), int'(SIdle));

        // Asynchronous reset in the middle of scoring.
        pulse1();
        gen4(16'h7654);
        v = '{g: 16'h3210, ex: 0, pa: 0, ch: 6, st: SInput};
        apply(v);
        for (int i = 0; i < 4; i++) enter(4'(i));
        pulse1();
        step();
        chk("mid_score", int'(state), int'(SScore));
        reset_n = 1'b0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_chances", int'(chances_left), 7);
        chk("arst_exact", int'(exact_cnt), 0);
        chk("arst_partial", int'(partial_cnt), 0);
        chk("arst_guess", int'(guess), 0);
        chk("arst_target", int'(target), 0);
        #1;
        reset_n = 1'b1;
        step();
        chk("post_rst_idle", int'(state), int'(SIdle));

        // Repeated digits on the permissive instance.
        pulse1();
        gen4(16'h4422);
        chk("rep_state", int'(b_state), int'(SInput));
        chk("rep_target", int'(b_target), 16'h4422);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] g;
            g = 16'h6242;
            enter(g[i*4 +: 4]);
        end
        chk("rep_guess", int'(b_guess), 16'h6242);
        pulse1();
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!b_score_valid && cyc < 30);
        chk("rep_latency", cyc, 9);
        chk("rep_exact", int'(b_exact_cnt), 1);
        chk("rep_partial", int'(b_partial_cnt), 2);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
